// File: rtl/bpm_test_link_checker_pkg.sv
// Shared constants and types for the BPM test-link checker: record magics,
// per-packet status codes and the record-walk state encoding.
package bpm_test_link_checker_pkg;

  localparam logic [15:0] BPM_TEST_HDR_MAGIC = 16'hA5BE;
  localparam logic [15:0] BPM_TEST_X_MAGIC   = 16'hCAFE;
  localparam logic [15:0] BPM_TEST_Y_MAGIC   = 16'hBEEF;

  typedef enum logic [1:0] {
    STATUS_OK      = 2'd0,
    STATUS_FORMAT  = 2'd1,
    STATUS_INDEX   = 2'd2,
    STATUS_FACYCLE = 2'd3
  } status_code_t;

  typedef enum logic [2:0] {
    REC_HDR,
    REC_X,
    REC_Y,
    REC_S,
    REC_DRAIN
  } rec_state_t;

endpackage

// File: rtl/bpm_test_link_checker_if.sv
// AXI-stream bundle carrying BPM test-link records from the writer (master)
// to the checker (slave).
interface bpm_test_link_checker_if;
  logic [31:0] rx_tdata;
  logic        rx_tvalid;
  logic        rx_tlast;
  logic        rx_tready;

  modport master (output rx_tdata, output rx_tvalid, output rx_tlast, input rx_tready);
  modport slave  (input rx_tdata, input rx_tvalid, input rx_tlast, output rx_tready);
endinterface

// File: rtl/bpm_test_lfsr.sv
// 16-bit maximal-length Galois LFSR (x^16+x^14+x^13+x^11+1) with enable and
// loadable seed; bit 0 is the pseudo-random output.
module bpm_test_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_bit
);

  logic [15:0] r_state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= SEED;
    end else if (i_en) begin
      r_state <= (r_state >> 1) ^ (r_state[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign o_bit = r_state[0];

endmodule

// File: rtl/bpm_test_link_checker.sv
// Checker for BPM test-link packets (HDR/X/Y/S records): one status per packet
// plus good/bad counters. Define BPM_CHECK_THROTTLE_EN for LFSR-driven backpressure.
module bpm_test_link_checker
  import bpm_test_link_checker_pkg::*;
#(
  parameter int BPM_COUNT        = 16,
  parameter int CELL_INDEX       = 12,
  parameter int BPM_GLOBAL_INDEX = 2,
  parameter int BPM_INDEX_WIDTH  = 5
) (
  input  logic                          auroraUserClk,
  input  logic                          auroraReset,
  bpm_test_link_checker_if.slave        rx,
  output logic                          statusStrobe,
  output logic [1:0]                    statusCode,
  output logic [31:0]                   goodCount,
  output logic [31:0]                   badCount,
  output logic [15:0]                   lastFAcycle
);

  localparam logic [BPM_INDEX_WIDTH-1:0] LAST_IDX = BPM_INDEX_WIDTH'(BPM_COUNT - 1);

  rec_state_t                 r_state;
  logic [BPM_INDEX_WIDTH-1:0] r_exp_idx;
  status_code_t               r_err;
  logic                       r_fa_valid;
  logic [15:0]                r_pkt_fa;
  logic                       r_s0_seen;
  logic                       r_run;
  logic                       r_status_strobe;
  status_code_t               r_status_code;
  logic [31:0]                r_good_count;
  logic [31:0]                r_bad_count;
  logic [15:0]                r_last_fa;

  logic                       w_throttle;
  logic                       w_beat;
  logic [31:0]                w_d;
  logic                       w_hdr_fmt_ok;
  logic                       w_hdr_idx_ok;
  logic                       w_word_idx_ok;
  logic                       w_fa_bad;
  logic                       w_is_rec0_s;
  status_code_t               w_code;
  status_code_t               w_err_final;
  logic                       w_end;
  rec_state_t                 w_next_state;
  logic [15:0]                w_pkt_fa_next;
  logic                       w_s0_next;

`ifdef BPM_CHECK_THROTTLE_EN
  bpm_test_lfsr #(.SEED(16'hACE1)) u_lfsr (
    .i_clk (auroraUserClk),
    .i_rst (auroraReset),
    .i_en  (1'b1),
    .o_bit (w_throttle)
  );
`else
  assign w_throttle = 1'b1;
`endif

  assign rx.rx_tready = r_run & w_throttle;
  assign w_beat       = rx.rx_tvalid & rx.rx_tready;
  assign w_d          = rx.rx_tdata;

  assign w_hdr_fmt_ok  = (w_d[31:16] == BPM_TEST_HDR_MAGIC) && w_d[15] &&
                         (w_d[14:10] == 5'(CELL_INDEX)) && !w_d[9] &&
                         (w_d[8:5] == 4'(BPM_GLOBAL_INDEX));
  assign w_hdr_idx_ok  = (w_d[4:0] == 5'(r_exp_idx));
  assign w_word_idx_ok = (w_d[15:0] == 16'(r_exp_idx));
  assign w_is_rec0_s   = (r_state == REC_S) && (r_exp_idx == '0);

  // Record 0 sets the packet FA cycle and is checked for continuity; later records must repeat it.
  assign w_fa_bad = w_is_rec0_s ? (r_fa_valid && (w_d[31:16] != r_last_fa + 16'd1))
                                : (w_d[31:16] != r_pkt_fa);

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    w_code       = STATUS_OK;
    w_end        = 1'b0;
    w_next_state = r_state;
    unique case (r_state)
      REC_HDR, REC_X, REC_Y: begin
        if (r_state == REC_HDR) begin
          if (!w_hdr_fmt_ok)      w_code = STATUS_FORMAT;
          else if (!w_hdr_idx_ok) w_code = STATUS_INDEX;
        end else begin
          if (w_d[31:16] != ((r_state == REC_X) ? BPM_TEST_X_MAGIC : BPM_TEST_Y_MAGIC))
            w_code = STATUS_FORMAT;
          else if (!w_word_idx_ok)
            w_code = STATUS_INDEX;
        end
        if (rx.rx_tlast) begin
          if (w_code == STATUS_OK) w_code = STATUS_INDEX;
          w_end        = 1'b1;
          w_next_state = REC_HDR;
        end else begin
          w_next_state = (r_state == REC_HDR) ? REC_X : (r_state == REC_X) ? REC_Y : REC_S;
        end
      end
      REC_S: begin
        if (!w_word_idx_ok) w_code = STATUS_INDEX;
        else if (w_fa_bad)  w_code = STATUS_FACYCLE;
        if (rx.rx_tlast) begin
          if (r_exp_idx != LAST_IDX && w_code == STATUS_OK) w_code = STATUS_INDEX;
          w_end        = 1'b1;
          w_next_state = REC_HDR;
        end else if (r_exp_idx == LAST_IDX) begin
          if (w_code == STATUS_OK) w_code = STATUS_INDEX;
          w_next_state = REC_DRAIN;
        end else begin
          w_next_state = REC_HDR;
        end
      end
      REC_DRAIN: begin
        if (rx.rx_tlast) begin
          w_end        = 1'b1;
          w_next_state = REC_HDR;
        end
      end
      default: w_next_state = REC_HDR;
    endcase
  end

  assign w_err_final   = (r_err != STATUS_OK) ? r_err : w_code;
  assign w_pkt_fa_next = w_is_rec0_s ? w_d[31:16] : r_pkt_fa;
  assign w_s0_next     = r_s0_seen | w_is_rec0_s;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge auroraUserClk) begin
    if (auroraReset) begin
      r_state         <= REC_HDR;
      r_exp_idx       <= '0;
      r_err           <= STATUS_OK;
      r_fa_valid      <= 1'b0;
      r_pkt_fa        <= '0;
      r_s0_seen       <= 1'b0;
      r_run           <= 1'b0;
      r_status_strobe <= 1'b0;
      r_status_code   <= STATUS_OK;
      r_good_count    <= '0;
      r_bad_count     <= '0;
      r_last_fa       <= '0;
    end else begin
      r_run           <= 1'b1;
      r_status_strobe <= 1'b0;
      if (w_beat) begin
        r_state   <= w_next_state;
        r_pkt_fa  <= w_pkt_fa_next;
        r_s0_seen <= w_s0_next;
        if (r_state == REC_S) r_exp_idx <= r_exp_idx + 1'b1;
        if (r_err == STATUS_OK) r_err <= w_code;
        // Packet end overrides the per-beat updates above.
        if (w_end) begin
          r_status_strobe <= 1'b1;
          r_status_code   <= w_err_final;
          if (w_err_final == STATUS_OK) r_good_count <= r_good_count + 32'd1;
          else                          r_bad_count  <= r_bad_count + 32'd1;
          if (w_s0_next) begin
            r_last_fa  <= w_pkt_fa_next;
            r_fa_valid <= 1'b1;
          end
          r_exp_idx <= '0;
          r_err     <= STATUS_OK;
          r_s0_seen <= 1'b0;
        end
      end
    end
  end

  assign statusStrobe = r_status_strobe;
  assign statusCode   = r_status_code;
  assign goodCount    = r_good_count;
  assign badCount     = r_bad_count;
  assign lastFAcycle  = r_last_fa;

endmodule

// File: tb/tb_bpm_test_link_checker.sv
// Directed bench for bpm_test_link_checker: writer-format packets with planted
// faults, run once back-to-back and once with random tvalid gaps.
module tb_bpm_test_link_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        status_strobe;
  logic [1:0]  status_code;
  logic [31:0] good_count;
  logic [31:0] bad_count;
  logic [15:0] last_fa;

  int n_tests  = 0;
  int n_fail   = 0;
  int n_strobe = 0;
  bit gaps     = 1'b0;

  bpm_test_link_checker_if rx_if ();

  bpm_test_link_checker dut (
    .auroraUserClk (clk),
    .auroraReset   (rst),
    .rx            (rx_if),
    .statusStrobe  (status_strobe),
    .statusCode    (status_code),
    .goodCount     (good_count),
    .badCount      (bad_count),
    .lastFAcycle   (last_fa)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (status_strobe === 1'b1) n_strobe++;

  function automatic logic [31:0] rec_word(input int r, input int w, input logic [15:0] fa);
    logic [15:0] idx;
    idx = 16'(r);
    case (w)
      0:       return {16'hA5BE, 1'b1, 5'd12, 1'b0, 4'd2, idx[4:0]};
      1:       return {16'hCAFE, idx};
      2:       return {16'hBEEF, idx};
      default: return {fa, idx};
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send_beat(input logic [31:0] d, input logic last);
    int n = 0;
    while (gaps && $urandom_range(0, 2) == 0) begin
      rx_if.rx_tvalid = 1'b0;
      @(negedge clk);
    end
    rx_if.rx_tvalid = 1'b1;
    rx_if.rx_tdata  = d;
    rx_if.rx_tlast  = last;
    while (rx_if.rx_tready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_timeout: tready stayed %0b, required 1", rx_if.rx_tready);
    end
    @(negedge clk);
    rx_if.rx_tvalid = 1'b0;
    rx_if.rx_tlast  = 1'b0;
  endtask

  // n_rec records, optional word override, optional drain tail, optional early stop.
  task automatic send_pkt(input logic [15:0] fa, input int n_rec, input int mod_rec,
                          input int mod_w, input logic [31:0] mod_val, input int extra,
                          input int stop_beats);
    int beats = 0;
    for (int r = 0; r < n_rec; r++) begin
      for (int w = 0; w < 4; w++) begin
        logic [31:0] word;
        if (stop_beats >= 0 && beats >= stop_beats) return;
        word = (r == mod_rec && w == mod_w) ? mod_val : rec_word(r, w, fa);
        send_beat(word, (w == 3) && (r == n_rec - 1) && (extra == 0));
        beats++;
      end
    end
    for (int e = 1; e <= extra; e++) send_beat(32'h1234_0000 + 32'(e), e == extra);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst             = 1'b1;
    rx_if.rx_tvalid = 1'b0;
    rx_if.rx_tlast  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    rx_if.rx_tvalid = 1'b0;
    rx_if.rx_tlast  = 1'b0;
    rx_if.rx_tdata  = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({rx_if.rx_tready, status_strobe, status_code} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: tready/strobe/code=%b, required 0000",
               {rx_if.rx_tready, status_strobe, status_code});
    end
    n_tests++;
    if ({good_count, bad_count, last_fa} !== 80'd0) begin
      n_fail++;
      $display("FAIL reset_counters: good=%0d bad=%0d lastFA=%0d, required 0 0 0",
               good_count, bad_count, last_fa);
    end
    rst = 1'b0;
    @(negedge clk);
`ifndef BPM_CHECK_THROTTLE_EN
    n_tests++;
    if (rx_if.rx_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %0b, required 1", rx_if.rx_tready);
    end
`endif
  endtask

  task automatic test_good();
    do_reset();
    send_pkt(16'd5, 16, -1, 0, 32'h0, 0, -1);
    n_tests++;
    if ({status_strobe, status_code} !== 3'b1_00) begin
      n_fail++;
      $display("FAIL good_status: strobe/code=%b, required 100", {status_strobe, status_code});
    end
    n_tests++;
    if (good_count !== 32'd1 || bad_count !== 32'd0 || last_fa !== 16'd5) begin
      n_fail++;
      $display("FAIL good_counts: good=%0d bad=%0d lastFA=%0d, required 1 0 5",
               good_count, bad_count, last_fa);
    end
    @(negedge clk);
    n_tests++;
    if (status_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL strobe_width: strobe=%0b one cycle later, required 0", status_strobe);
    end
  endtask

  task automatic test_continuity();
    do_reset();
    send_pkt(16'd5, 16, -1, 0, 32'h0, 0, -1);
    send_pkt(16'd6, 16, -1, 0, 32'h0, 0, -1);
    n_tests++;
    if ({status_strobe, status_code} !== 3'b1_00 || good_count !== 32'd2) begin
      n_fail++;
      $display("FAIL fa_next: strobe/code=%b good=%0d, required 100 2",
               {status_strobe, status_code}, good_count);
    end
    send_pkt(16'd8, 16, -1, 0, 32'h0, 0, -1);
    n_tests++;
    if ({status_strobe, status_code} !== 3'b1_11 || bad_count !== 32'd1 || last_fa !== 16'd8) begin
      n_fail++;
      $display("FAIL fa_skip: strobe/code=%b bad=%0d lastFA=%0d, required 111 1 8",
               {status_strobe, status_code}, bad_count, last_fa);
    end
  endtask

  task automatic test_format();
    do_reset();
    send_pkt(16'd10, 16, 3, 1, 32'hCAFF_0003, 0, -1);
    n_tests++;
    if ({status_strobe, status_code} !== 3'b1_01 || bad_count !== 32'd1) begin
      n_fail++;
      $display("FAIL x_magic: strobe/code=%b bad=%0d, required 101 1",
               {status_strobe, status_code}, bad_count);
    end
    send_pkt(16'd11, 16, 3, 2, 32'hBEEF_0007, 0, -1);
    n_tests++;
    if ({status_strobe, status_code} !== 3'b1_10 || bad_count !== 32'd2 || good_count !== 32'd0) begin
      n_fail++;
      $display("FAIL y_index: strobe/code=%b bad=%0d good=%0d, required 110 2 0",
               {status_strobe, status_code}, bad_count, good_count);
    end
  endtask

  task automatic test_short();
    do_reset();
    send_pkt(16'd20, 10, -1, 0, 32'h0, 0, -1);
    n_tests++;
    if ({status_strobe, status_code} !== 3'b1_10 || last_fa !== 16'd20) begin
      n_fail++;
      $display("FAIL short_pkt: strobe/code=%b lastFA=%0d, required 110 20",
               {status_strobe, status_code}, last_fa);
    end
    send_pkt(16'd21, 16, -1, 0, 32'h0, 0, -1);
    n_tests++;
    if ({status_strobe, status_code} !== 3'b1_00 || good_count !== 32'd1 || bad_count !== 32'd1) begin
      n_fail++;
      $display("FAIL after_short: strobe/code=%b good=%0d bad=%0d, required 100 1 1",
               {status_strobe, status_code}, good_count, bad_count);
    end
  endtask

  task automatic test_drain();
    int s0;
    do_reset();
    s0 = n_strobe;
    send_pkt(16'd30, 16, -1, 0, 32'h0, 3, -1);
    n_tests++;
    if ({status_strobe, status_code} !== 3'b1_10 || bad_count !== 32'd1) begin
      n_fail++;
      $display("FAIL drain_status: strobe/code=%b bad=%0d, required 110 1",
               {status_strobe, status_code}, bad_count);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (n_strobe - s0 !== 1) begin
      n_fail++;
      $display("FAIL drain_strobes: saw %0d strobes, required 1", n_strobe - s0);
    end
    send_pkt(16'd31, 16, -1, 0, 32'h0, 0, -1);
    n_tests++;
    if ({status_strobe, status_code} !== 3'b1_00 || good_count !== 32'd1 || last_fa !== 16'd31) begin
      n_fail++;
      $display("FAIL after_drain: strobe/code=%b good=%0d lastFA=%0d, required 100 1 31",
               {status_strobe, status_code}, good_count, last_fa);
    end
  endtask

  task automatic test_reset_mid();
    int s0;
    do_reset();
    s0 = n_strobe;
    send_pkt(16'd39, 16, -1, 0, 32'h0, 0, 29);
    do_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if (n_strobe - s0 !== 0 || good_count !== 32'd0 || bad_count !== 32'd0 || last_fa !== 16'd0) begin
      n_fail++;
      $display("FAIL abort: strobes=%0d good=%0d bad=%0d lastFA=%0d, required 0 0 0 0",
               n_strobe - s0, good_count, bad_count, last_fa);
    end
    send_pkt(16'd40, 16, -1, 0, 32'h0, 0, -1);
    n_tests++;
    if ({status_strobe, status_code} !== 3'b1_00 || good_count !== 32'd1 || last_fa !== 16'd40) begin
      n_fail++;
      $display("FAIL after_abort: strobe/code=%b good=%0d lastFA=%0d, required 100 1 40",
               {status_strobe, status_code}, good_count, last_fa);
    end
  endtask

  initial begin
    test_reset();
    for (int pass = 0; pass < 2; pass++) begin
      gaps = (pass == 1);
      test_good();
      test_continuity();
      test_format();
      test_short();
      test_drain();
      test_reset_mid();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
